// File: rtl/mxn_table_gen.sv
// mxn_table_gen
//   Builds the digit-multiple tables consumed by the radix-2^PBITS interleaved
//   modular multiplier:
//     mxn[k] = k*m           for k = 1..MLSIZE   (mxn[0] reads as 0)
//     bxn[k] = (k*b) mod m   for k = 0..MLSIZE-1 (bxn[MLSIZE] reads as 0)
//   One table row is produced per clock by accumulating m and b, so a build
//   takes MLSIZE-1 cycles after the start edge.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          begin a build (sampled only while idle); latches m and b
//   abort          cancel a build in progress
//   m, b           modulus and operand (b < m, m != 0)
//   busy           build in progress
//   done           one-cycle pulse when the tables are complete
//   tbl_valid      tables hold the results for the last accepted m/b
//   rd_en, rd_idx  table read request and index (0..MLSIZE)
//   rd_vld         read data valid, one cycle after rd_en
//   mxn_rd, bxn_rd registered read data (held while rd_vld is low)
module mxn_table_gen #(
  parameter int NBITS  = 4096,
  parameter int PBITS  = 2,
  parameter int MLSIZE = 1 << PBITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NBITS-1:0]       m,
  input  logic [NBITS-1:0]       b,
  output logic                   busy,
  output logic                   done,
  output logic                   tbl_valid,
  input  logic                   rd_en,
  input  logic [PBITS:0]         rd_idx,
  output logic                   rd_vld,
  output logic [NBITS+PBITS-1:0] mxn_rd,
  output logic [NBITS-1:0]       bxn_rd
);

  localparam int MW = NBITS + PBITS;
  localparam int KW = PBITS + 1;
  localparam logic [KW-1:0] K_LAST  = KW'(MLSIZE);
  localparam logic [KW-1:0] K_FIRST = KW'(2);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_nxt;
  logic              accept, fill_step, last;

  logic [NBITS-1:0]  m_q, b_q;
  logic [MW-1:0]     macc, macc_nxt;
  logic [NBITS-1:0]  bacc, bacc_nxt;
  logic [KW-1:0]     k;

  // mxn_tbl[0] and bxn_tbl[MLSIZE] are never written, so they read back as 0.
  logic [MW-1:0]     mxn_tbl [0:MLSIZE];
  logic [NBITS-1:0]  bxn_tbl [0:MLSIZE];

  // (a + x) mod md for a, x < md; the sum needs one guard bit.
  function automatic logic [NBITS-1:0] mod_add(input logic [NBITS-1:0] a,
                                               input logic [NBITS-1:0] x,
                                               input logic [NBITS-1:0] md);
    logic [NBITS:0] t;
    t = {1'b0, a} + {1'b0, x};
    if (t >= {1'b0, md}) t = t - {1'b0, md};
    return t[NBITS-1:0];
  endfunction

  assign macc_nxt = macc + {{PBITS{1'b0}}, m_q};
  assign bacc_nxt = mod_add(bacc, b_q, m_q);
  assign last     = (k == K_LAST);
  assign busy     = (state == FILL);

  // Next-state logic; abort takes priority over the final fill step.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fill_step = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          fill_step = 1'b1;
          if (last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Build stage: accumulators, counter, table writes and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      b_q       <= '0;
      macc      <= '0;
      bacc      <= '0;
      k         <= '0;
      done      <= 1'b0;
      tbl_valid <= 1'b0;
      for (int i = 0; i <= MLSIZE; i++) begin
        mxn_tbl[i] <= '0;
        bxn_tbl[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (accept) begin
        m_q        <= m;
        b_q        <= b;
        macc       <= {{PBITS{1'b0}}, m};
        bacc       <= b;
        k          <= K_FIRST;
        mxn_tbl[1] <= {{PBITS{1'b0}}, m};
        bxn_tbl[0] <= '0;
        bxn_tbl[1] <= b;
        tbl_valid  <= 1'b0;
      end else if (fill_step) begin
        macc       <= macc_nxt;
        bacc       <= bacc_nxt;
        mxn_tbl[k] <= macc_nxt;
        if (k < K_LAST) bxn_tbl[k] <= bacc_nxt;
        k <= k + 1'b1;
        if (last) begin
          done      <= 1'b1;
          tbl_valid <= 1'b1;
        end
      end else if (state == FILL) begin
        tbl_valid <= 1'b0;
      end
    end
  end

  // Read stage: one registered lookup per cycle, old contents on a same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      mxn_rd <= '0;
      bxn_rd <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) begin
        mxn_rd <= (rd_idx <= K_LAST) ? mxn_tbl[rd_idx] : '0;
        bxn_rd <= (rd_idx <= K_LAST) ? bxn_tbl[rd_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_mxn_table_gen.sv
// Bench for mxn_table_gen: two instances (PBITS=2 and PBITS=1, NBITS=8),
// a cycle-level reference model built from the table definitions
// (k*m and (k*b) mod m), a per-cycle compare process, and directed
// literal checks for latency and table contents.
module tb_mxn_table_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       abort0 = 1'b0, abort1 = 1'b0;
  logic [7:0] m = '0, b = '0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_idx = '0;

  logic       busy0, done0, tv0, rdv0;
  logic [9:0] mxn_rd0;
  logic [7:0] bxn_rd0;
  logic       busy1, done1, tv1, rdv1;
  logic [8:0] mxn_rd1;
  logic [7:0] bxn_rd1;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mxn_table_gen #(.NBITS(8), .PBITS(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .m(m), .b(b),
    .busy(busy0), .done(done0), .tbl_valid(tv0), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_vld(rdv0), .mxn_rd(mxn_rd0), .bxn_rd(bxn_rd0)
  );

  mxn_table_gen #(.NBITS(8), .PBITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .m(m), .b(b),
    .busy(busy1), .done(done1), .tbl_valid(tv1), .rd_en(rd_en), .rd_idx(rd_idx[1:0]),
    .rd_vld(rdv1), .mxn_rd(mxn_rd1), .bxn_rd(bxn_rd1)
  );

  // ---------------- reference model ----------------
  logic e_busy [2];
  logic e_done [2];
  logic e_tv   [2];
  logic e_rdv  [2];
  int   e_mrd  [2];
  int   e_brd  [2];
  int   e_k    [2];
  int   e_m    [2];
  int   e_b    [2];
  int   e_mxn  [2][5];
  int   e_bxn  [2][5];

  function automatic int ml(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int mod_safe(input int x, input int md);
    return (md == 0) ? 0 : x % md;
  endfunction

  function automatic int tbl_rd(input int i, input bit sel_m);
    int idx;
    idx = (i == 0) ? int'(rd_idx) : int'(rd_idx[1:0]);
    if (idx > ml(i)) return 0;
    return sel_m ? e_mxn[i][idx] : e_bxn[i][idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        e_busy[i] <= 1'b0; e_done[i] <= 1'b0; e_tv[i] <= 1'b0; e_rdv[i] <= 1'b0;
        e_mrd[i] <= 0; e_brd[i] <= 0; e_k[i] <= 0; e_m[i] <= 0; e_b[i] <= 0;
        for (int j = 0; j < 5; j++) begin
          e_mxn[i][j] <= 0;
          e_bxn[i][j] <= 0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        e_rdv[i]  <= rd_en;
        if (rd_en) begin
          e_mrd[i] <= tbl_rd(i, 1'b1);
          e_brd[i] <= tbl_rd(i, 1'b0);
        end
        e_done[i] <= 1'b0;
        if (!e_busy[i]) begin
          if ((i == 0) ? start0 : start1) begin
            e_m[i] <= int'(m);
            e_b[i] <= int'(b);
            e_mxn[i][1] <= int'(m);
            e_bxn[i][0] <= 0;
            e_bxn[i][1] <= mod_safe(int'(b), int'(m));
            e_k[i] <= 2;
            e_busy[i] <= 1'b1;
            e_tv[i] <= 1'b0;
          end
        end else if ((i == 0) ? abort0 : abort1) begin
          e_busy[i] <= 1'b0;
          e_tv[i] <= 1'b0;
        end else begin
          e_mxn[i][e_k[i]] <= e_k[i] * e_m[i];
          if (e_k[i] < ml(i)) e_bxn[i][e_k[i]] <= mod_safe(e_k[i] * e_b[i], e_m[i]);
          if (e_k[i] == ml(i)) begin
            e_busy[i] <= 1'b0;
            e_done[i] <= 1'b1;
            e_tv[i] <= 1'b1;
          end
          e_k[i] <= e_k[i] + 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("busy0", busy0, e_busy[0]);
      chk("done0", done0, e_done[0]);
      chk("tbl_valid0", tv0, e_tv[0]);
      chk("rd_vld0", rdv0, e_rdv[0]);
      chk("mxn_rd0", mxn_rd0, e_mrd[0]);
      chk("bxn_rd0", bxn_rd0, e_brd[0]);
      chk("busy1", busy1, e_busy[1]);
      chk("done1", done1, e_done[1]);
      chk("tbl_valid1", tv1, e_tv[1]);
      chk("rd_vld1", rdv1, e_rdv[1]);
      chk("mxn_rd1", mxn_rd1, e_mrd[1]);
      chk("bxn_rd1", bxn_rd1, e_brd[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic build(input int inst, input int mv, input int bv, input int exp_lat);
    int  lat;
    bit  seen;
    @(negedge clk);
    m = 8'(mv);
    b = 8'(bv);
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      seen = (inst == 0) ? done0 : done1;
    end
    chk("done_latency", lat, exp_lat);
    chk("tbl_valid_at_done", (inst == 0) ? tv0 : tv1, 1);
  endtask

  task automatic rd_lit(input int inst, input int idx, input int em, input int eb);
    @(negedge clk);
    rd_en  = 1'b1;
    rd_idx = 3'(idx);
    @(posedge clk);
    #1;
    if (inst == 0) begin
      chk("lit_rd_vld0", rdv0, 1);
      chk("lit_mxn0", mxn_rd0, em);
      chk("lit_bxn0", bxn_rd0, eb);
    end else begin
      chk("lit_rd_vld1", rdv1, 1);
      chk("lit_mxn1", mxn_rd1, em);
      chk("lit_bxn1", bxn_rd1, eb);
    end
  endtask

  task automatic rd_off();
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int ndone;
    int exp_m [5];
    int exp_b [5];
    exp_m = '{0, 200, 400, 600, 800};
    exp_b = '{0, 150, 100, 50, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_tv0", tv0, 0);
    chk("rst_rdv0", rdv0, 0);
    chk("rst_mxn0", mxn_rd0, 0);
    chk("rst_bxn0", bxn_rd0, 0);
    rst_n = 1'b1;

    // m=200, b=150, PBITS=2
    build(0, 200, 150, 3);
    for (int i = 0; i <= 4; i++) rd_lit(0, i, exp_m[i], exp_b[i]);
    rd_off();

    // start held for cycles 0..2: only one build, one done
    @(negedge clk);
    m = 8'd200; b = 8'd150; start0 = 1'b1;
    @(negedge clk);
    m = 8'd99; b = 8'd7;
    @(negedge clk);
    @(negedge clk);
    start0 = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done0) ndone++;
    end
    chk("repulse_done_count", ndone, 1);
    for (int i = 0; i <= 4; i++) rd_lit(0, i, exp_m[i], exp_b[i]);
    rd_off();

    // m=13, b=12
    build(0, 13, 12, 3);
    rd_lit(0, 0, 0, 0);
    rd_lit(0, 1, 13, 12);
    rd_lit(0, 2, 26, 11);
    rd_lit(0, 3, 39, 10);
    rd_lit(0, 4, 52, 0);
    rd_off();

    // abort a build of m=7, b=3 in cycle 1
    @(negedge clk);
    m = 8'd7; b = 8'd3; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; abort0 = 1'b1;
    chk("busy_before_abort", busy0, 1);
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_tbl_valid", tv0, 0);
    ndone = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done0) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    // PBITS=1, m=255, b=254
    build(1, 255, 254, 1);
    rd_lit(1, 0, 0, 0);
    rd_lit(1, 1, 255, 254);
    rd_lit(1, 2, 510, 0);
    rd_off();

    // back-to-back reads 4,3,2 after rebuilding m=200, b=150
    build(0, 200, 150, 3);
    rd_lit(0, 4, 800, 0);
    rd_lit(0, 3, 600, 50);
    rd_lit(0, 2, 400, 100);
    rd_off();

    // reset in the middle of a build
    @(negedge clk);
    m = 8'd100; b = 8'd60; start0 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    chk("midfill_busy0", busy0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy0", busy0, 0);
    chk("midrst_busy1", busy1, 0);
    chk("midrst_tv0", tv0, 0);
    chk("midrst_mxn0", mxn_rd0, 0);
    chk("midrst_bxn0", bxn_rd0, 0);
    chk("midrst_done0", done0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    build(0, 200, 150, 3);
    for (int i = 0; i <= 4; i++) rd_lit(0, i, exp_m[i], exp_b[i]);
    rd_off();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
